// File: rtl/mul_pipe_acc_if.sv
// Job / operand / result bundle between mul_pipe_acc and its environment.
// The master side drives job requests, operand valid, the multiplier product
// and the result ready; the slave side (mul_pipe_acc) answers with status,
// operand ready and the accumulated result.
interface mul_pipe_acc_if #(
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
);

   logic             start;
   logic [CNT_W-1:0] len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       mul_out;
   logic [ACC_W-1:0] acc_out;
   logic             acc_valid;
   logic             acc_ready;
   logic             ovf;

   modport master (
      output start,
      output len,
      output in_valid,
      output mul_out,
      output acc_ready,
      input  busy,
      input  in_ready,
      input  acc_out,
      input  acc_valid,
      input  ovf
   );

   modport slave (
      input  start,
      input  len,
      input  in_valid,
      input  mul_out,
      input  acc_ready,
      output busy,
      output in_ready,
      output acc_out,
      output acc_valid,
      output ovf
   );

endinterface

// File: rtl/mul_pipe_acc.sv
// Accumulator and issue controller for the 4-bit pipelined multiplier.
// Accepts a job of len operand pairs, tracks in-flight products with a valid
// delay line matched to the multiplier latency (LAT), sums the 8-bit products
// and presents the sum on a valid/ready result port.
// Optional build macro: MUL_PIPE_ACC_SATURATE_EN -- clamp the sum to all-ones
// on overflow instead of wrapping modulo 2^ACC_W.
module mul_pipe_acc #(
   parameter int unsigned LAT   = 3,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
) (
   input logic           clk,
   input logic           rst_n,
   mul_pipe_acc_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] issue_cnt_q;
   logic [CNT_W-1:0] recv_cnt_q;
   logic [CNT_W-1:0] recv_cnt_inc;
   logic [LAT-1:0]   vld_dly_q;
   logic [LAT-1:0]   vld_dly_d;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_next;
   logic [ACC_W:0]   sum_ext;
   logic             ovf_q;
   logic             busy_q;
   logic             acc_valid_q;
   logic             in_ready_c;
   logic             accept;
   logic             capture;
   logic             carry;

   // Issue gating, capture decode and the next accumulator value.
   always_comb begin
      in_ready_c   = (state_q == StRun) && (issue_cnt_q < len_q);
      accept       = in_ready_c && bus.in_valid;
      // The oldest delay-line bit marks mul_out as holding a tracked product.
      capture      = vld_dly_q[LAT-1];
      sum_ext      = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.mul_out};
      carry        = sum_ext[ACC_W];
`ifdef MUL_PIPE_ACC_SATURATE_EN
      // Once saturated, the sum stays pinned for the rest of the job.
      acc_next     = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
      acc_next     = sum_ext[ACC_W-1:0];
`endif
      recv_cnt_inc = recv_cnt_q + CntOne;
   end

   // Valid delay line input: shift in a 1 for every accepted operand pair.
   if (LAT == 1) begin : g_dly_one
      assign vld_dly_d = accept;
   end else begin : g_dly_multi
      assign vld_dly_d = {vld_dly_q[LAT-2:0], accept};
   end

   // Job FSM with counters, delay line, accumulator and registered status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         len_q       <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         vld_dly_q   <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         acc_valid_q <= 1'b0;
      end else begin
         // Shift and capture run in every state; only RUN can inject 1s.
         vld_dly_q <= vld_dly_d;
         if (capture) begin
            acc_q      <= acc_next;
            recv_cnt_q <= recv_cnt_inc;
            if (carry) begin
               ovf_q <= 1'b1;
            end
         end
         if (accept) begin
            issue_cnt_q <= issue_cnt_q + CntOne;
         end

         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  len_q       <= bus.len;
                  acc_q       <= '0;
                  ovf_q       <= 1'b0;
                  issue_cnt_q <= '0;
                  recv_cnt_q  <= '0;
                  busy_q      <= 1'b1;
                  if (bus.len != '0) begin
                     state_q <= StRun;
                  end else begin
                     // Empty job: present a zero result straight away.
                     state_q     <= StHold;
                     acc_valid_q <= 1'b1;
                  end
               end
            end
            StRun: begin
               // The capture that brings recv_cnt up to len_q ends the job.
               if (capture && (recv_cnt_inc == len_q)) begin
                  state_q     <= StHold;
                  acc_valid_q <= 1'b1;
               end
            end
            StHold: begin
               // start is ignored here, even alongside the handshake.
               if (acc_valid_q && bus.acc_ready) begin
                  state_q     <= StIdle;
                  acc_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= StIdle;
               acc_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.in_ready  = in_ready_c;
   assign bus.acc_out   = acc_q;
   assign bus.acc_valid = acc_valid_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mul_pipe_acc.sv
// Directed self-checking bench for mul_pipe_acc. A behavioural model of the
// 3-stage 4-bit multiplier feeds both a 16-bit accumulator instance and an
// 8-bit one used for the overflow case.
module tb_mul_pipe_acc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] mul_a = '0;
   logic [3:0] mul_b = '0;
   logic [3:0] a1_q, b1_q;
   logic [7:0] p2_q, p3_q;
   int checks = 0;
   int errors = 0;
   int wait_n;

   always #5 clk = ~clk;

   mul_pipe_acc_if #(.ACC_W(16), .CNT_W(8)) b ();
   mul_pipe_acc_if #(.ACC_W(8),  .CNT_W(8)) c ();

   mul_pipe_acc #(.LAT(3), .ACC_W(16), .CNT_W(8)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   mul_pipe_acc #(.LAT(3), .ACC_W(8), .CNT_W(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (c)
   );

   // Multiplier model: operands sampled at E0, product on mul_out after E0+2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q <= '0;
         b1_q <= '0;
         p2_q <= '0;
         p3_q <= '0;
      end else begin
         a1_q <= mul_a;
         b1_q <= mul_b;
         p2_q <= 8'(a1_q) * 8'(b1_q);
         p3_q <= p2_q;
      end
   end

   assign b.mul_out = p3_q;
   assign c.mul_out = p3_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [7:0] l);
      b.len   = l;
      b.start = 1'b1;
      tick();
      b.start = 1'b0;
   endtask

   // Present one pair on the 16-bit instance, optionally after an idle cycle.
   task automatic send(input logic [3:0] a, input logic [3:0] bb, input bit stall);
      int n;
      if (stall) begin
         b.in_valid = 1'b0;
         tick();
      end
      mul_a = a;
      mul_b = bb;
      b.in_valid = 1'b1;
      n = 0;
      while (!b.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("send_ready", b.in_ready, 1);
      tick();
      b.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      wait_n = 0;
      while (!b.acc_valid && wait_n < 20) begin
         tick();
         wait_n++;
      end
      check(tag, b.acc_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      b.start = 0; b.len = 0; b.in_valid = 0; b.acc_ready = 1;
      c.start = 0; c.len = 0; c.in_valid = 0; c.acc_ready = 1;

      // Reset state
      tick();
      tick();
      check("rst_busy", b.busy, 0);
      check("rst_valid", b.acc_valid, 0);
      check("rst_acc", b.acc_out, 0);
      check("rst_ovf", b.ovf, 0);
      check("rst_ready", b.in_ready, 0);
      rst_n = 1'b1;
      tick();

      // Basic job: (3,5),(15,15),(0,7),(9,2) back-to-back -> 258
      start_job(8'd4);
      check("basic_busy", b.busy, 1);
      check("basic_ready0", b.in_ready, 1);
      send(4'd3, 4'd5, 1'b0);
      send(4'd15, 4'd15, 1'b0);
      send(4'd0, 4'd7, 1'b0);
      send(4'd9, 4'd2, 1'b0);        // last accept edge E4
      check("basic_ready_drop", b.in_ready, 0);
      check("basic_acc_e4", b.acc_out, 15);
      check("basic_valid_e4", b.acc_valid, 0);
      tick();
      check("basic_acc_e5", b.acc_out, 240);
      check("basic_valid_e5", b.acc_valid, 0);
      tick();
      check("basic_valid_e6", b.acc_valid, 0);
      tick();                         // E4+3
      check("basic_valid_e7", b.acc_valid, 1);
      check("basic_acc", b.acc_out, 258);
      check("basic_ovf", b.ovf, 0);
      tick();
      check("basic_valid_single", b.acc_valid, 0);
      check("basic_idle", b.busy, 0);
      check("basic_acc_kept", b.acc_out, 258);

      // Stalled input: same job, in_valid low on alternate cycles
      start_job(8'd4);
      send(4'd3, 4'd5, 1'b1);
      send(4'd15, 4'd15, 1'b1);
      send(4'd0, 4'd7, 1'b1);
      send(4'd9, 4'd2, 1'b1);
      check("stall_ready_drop", b.in_ready, 0);
      wait_valid("stall_valid");
      check("stall_acc", b.acc_out, 258);
      check("stall_ovf", b.ovf, 0);
      tick();
      check("stall_idle", b.busy, 0);

      // Reset mid-job with two products in flight
      start_job(8'd4);
      send(4'd3, 4'd5, 1'b0);
      send(4'd4, 4'd4, 1'b0);
      send(4'd5, 4'd5, 1'b0);
      tick();
      check("mid_acc_partial", b.acc_out, 15);
      check("mid_busy", b.busy, 1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_acc", b.acc_out, 0);
      check("mid_rst_valid", b.acc_valid, 0);
      check("mid_rst_busy", b.busy, 0);
      check("mid_rst_ready", b.in_ready, 0);
      rst_n = 1'b1;
      tick();
      start_job(8'd1);
      send(4'd2, 4'd3, 1'b0);
      wait_valid("mid_job_valid");
      check("mid_job_acc", b.acc_out, 6);
      tick();

      // Zero-length job
      start_job(8'd0);
      check("zero_valid", b.acc_valid, 1);
      check("zero_acc", b.acc_out, 0);
      check("zero_busy", b.busy, 1);
      tick();
      check("zero_done", b.acc_valid, 0);

      // Backpressure: result held, start pulses in HOLD ignored
      b.acc_ready = 1'b0;
      start_job(8'd2);
      send(4'd1, 4'd1, 1'b0);
      send(4'd2, 4'd2, 1'b0);
      wait_valid("bp_valid");
      check("bp_acc", b.acc_out, 5);
      for (int i = 0; i < 5; i++) begin
         b.start = i[0];
         b.len   = 8'd7;
         tick();
         check("bp_hold_valid", b.acc_valid, 1);
         check("bp_hold_acc", b.acc_out, 5);
         check("bp_hold_busy", b.busy, 1);
         check("bp_hold_ready", b.in_ready, 0);
      end
      b.acc_ready = 1'b1;
      b.start = 1'b1;                 // coincides with handshake: ignored
      tick();
      b.start = 1'b0;
      check("bp_release_valid", b.acc_valid, 0);
      check("bp_release_busy", b.busy, 0);
      tick();
      check("bp_still_idle", b.busy, 0);
      check("bp_acc_kept", b.acc_out, 5);

      // Overflow on the 8-bit instance: (15,15),(15,15)
      c.len = 8'd2;
      c.start = 1'b1;
      tick();
      c.start = 1'b0;
      check("ovf_ready", c.in_ready, 1);
      mul_a = 4'd15;
      mul_b = 4'd15;
      c.in_valid = 1'b1;
      tick();                         // E1
      tick();                         // E2
      c.in_valid = 1'b0;
      tick();                         // E3
      tick();                         // E4
      check("ovf_acc_first", c.acc_out, 225);
      check("ovf_flag_first", c.ovf, 0);
      tick();                         // E5
      check("ovf_valid", c.acc_valid, 1);
`ifdef MUL_PIPE_ACC_SATURATE_EN
      check("ovf_acc", c.acc_out, 255);
`else
      check("ovf_acc", c.acc_out, 194);
`endif
      check("ovf_flag", c.ovf, 1);
      tick();
      check("ovf_idle", c.busy, 0);
      check("ovf_sticky_idle", c.ovf, 1);

      // Next start clears ovf
      c.len = 8'd1;
      c.start = 1'b1;
      tick();
      c.start = 1'b0;
      check("ovf_clear", c.ovf, 0);
      mul_a = 4'd1;
      mul_b = 4'd1;
      c.in_valid = 1'b1;
      tick();
      c.in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("ovf2_valid", c.acc_valid, 1);
      check("ovf2_acc", c.acc_out, 1);
      check("ovf2_flag", c.ovf, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
